// File: rtl/div_frec_pkg.sv
// Shared constants for the div_frec programmable clock divider.
package div_frec_pkg;

   localparam int unsigned DIV_FREC_WIDTH = 16;

endpackage : div_frec_pkg

// File: rtl/div_frec_if.sv
// Divider control/output bundle: divide value in, divided clock out.
interface div_frec_if
   import div_frec_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_FREC_WIDTH
);

   logic [WIDTH-1:0] div;
   logic             clkd;

   // Consumer side: programs div, observes clkd
   modport master (
      output div,
      input  clkd
   );

   // Divider side: reads div, drives clkd
   modport slave (
      input  div,
      output clkd
   );

endinterface : div_frec_if

// File: rtl/div_frec_counter.sv
// WIDTH-bit up counter with synchronous clear and a terminal flag (count >= limit).
module div_frec_counter
   import div_frec_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_FREC_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic             terminal_c
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // '>=' rather than '==' so a lowered limit ends the half-period at once instead of wrapping
   assign terminal_c = (cnt_q >= limit_i);

   // Next count: clear on request, otherwise increment (clear always wins at all-ones)
   always_comb begin
      cnt_d = WIDTH'(cnt_q + 1'b1);
      if (clr_i) begin
         cnt_d = '0;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : div_frec_counter

// File: rtl/div_frec.sv
// Programmable frequency divider: clkd half-period = div+1 clk cycles.
// Optional macro DIV_FREC_DIV_LATCH_EN retimes div changes to half-period boundaries.
module div_frec
   import div_frec_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_FREC_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   div_frec_if.slave  bus
);

   logic             terminal;
   logic [WIDTH-1:0] div_eff;
   logic             clkd_q;
   logic             clkd_d;

`ifdef DIV_FREC_DIV_LATCH_EN
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] div_d;

   // Resample div only when a half-period ends; reset value 0 gives a 1-cycle first half-period
   always_comb begin
      div_d = div_q;
      if (terminal) begin
         div_d = bus.div;
      end
   end

   // Latched divide value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign div_eff = div_q;
`else
   assign div_eff = bus.div;
`endif

   // Half-period counter, cleared each time it reaches the effective limit
   div_frec_counter #(
      .WIDTH      (WIDTH)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (terminal),
      .limit_i    (div_eff),
      .terminal_c (terminal)
   );

   // Toggle the divided clock at every half-period boundary
   always_comb begin
      clkd_d = clkd_q;
      if (terminal) begin
         clkd_d = ~clkd_q;
      end
   end

   // Divided clock flop; the only driver of clkd
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clkd_q <= 1'b0;
      end else begin
         clkd_q <= clkd_d;
      end
   end

   assign bus.clkd = clkd_q;

endmodule : div_frec

// File: tb/tb_div_frec.sv
// Self-checking bench for div_frec: directed steps plus randomized divide values,
// checked every cycle against a cycles-since-boundary reference model.
`timescale 1ns/1ps
module tb_div_frec;
   import div_frec_pkg::*;

   localparam int unsigned W = DIV_FREC_WIDTH;

   logic clk;
   logic rst;

   div_frec_if #(.WIDTH(W)) dif ();

   div_frec #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: cycles elapsed in the current half-period and expected clkd
   int m_elapsed = 0;
   bit m_clkd    = 1'b0;
   int m_lat     = 0;

   task automatic model_reset();
      m_elapsed = 0;
      m_clkd    = 1'b0;
      m_lat     = 0;
   endtask

   task automatic model_edge();
      int eff;
`ifdef DIV_FREC_DIV_LATCH_EN
      eff = m_lat;
`else
      eff = int'(dif.div);
`endif
      m_elapsed = m_elapsed + 1;
      if (m_elapsed >= eff + 1) begin
         m_elapsed = 0;
         m_clkd    = ~m_clkd;
         m_lat     = int'(dif.div);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: advance model on the edge, compare 1 ns later
   task automatic tick(input string tag);
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      chk_bit(tag, dif.clkd, m_clkd);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      run("reset_hold", 2);
      rst = 1'b0;
   endtask

   initial begin
      logic prev;
      int   n;

      // 1. Reset held for 3 cycles with div=499
      rst     = 1'b1;
      dif.div = 16'd499;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk_bit("rst_clkd", dif.clkd, 1'b0);
         chk_int("rst_cnt", int'(dut.u_cnt.cnt_q), 0);
      end

      // 2. div=499: half-period 500 cycles, one full period
      rst = 1'b0;
      run("div499", 1000);

      // 3. div=0: toggle every cycle
      do_reset();
      dif.div = '0;
      run("div0", 8);
      chk_int("div0_cnt", int'(dut.u_cnt.cnt_q), 0);

      // 4. div=9, lowered to 2 when counter reaches 7
      do_reset();
      dif.div = 16'd9;
      run("div9_pre", 12);
      n = 0;
      while (m_elapsed != 7 && n < 40) begin
         tick("div9_run");
         n++;
      end
      chk_int("div9_reach7", m_elapsed, 7);
      dif.div = 16'd2;
      prev = dif.clkd;
      tick("div_lower_edge");
`ifndef DIV_FREC_DIV_LATCH_EN
      chk_bit("div_lower_toggle", dif.clkd, ~prev);
`endif
      run("div_lower_after", 12);

      // Randomized divide values, including raises and drops mid-count
      for (int s = 0; s < 25; s++) begin
         dif.div = W'($urandom_range(0, 20));
         run("rand", int'($urandom_range(5, 60)));
      end

      // 5. Async reset while clkd is high, between clock edges
      do_reset();
      dif.div = 16'd5;
      n = 0;
      while (m_clkd != 1'b1 && n < 40) begin
         tick("pre_async");
         n++;
      end
      run("mid_high", 2);
      chk_bit("async_pre_high", dif.clkd, 1'b1);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk_bit("async_clkd", dif.clkd, 1'b0);
      chk_int("async_cnt", int'(dut.u_cnt.cnt_q), 0);
      run("async_hold", 2);
      rst = 1'b0;

      // 6. div=all-ones: half-period exactly 65536 cycles
      dif.div = 16'hFFFF;
`ifdef DIV_FREC_DIV_LATCH_EN
      tick("ffff_first");
`endif
      prev = dif.clkd;
      n = 0;
      while (dif.clkd === prev && n < 70000) begin
         tick("ffff_run");
         n++;
      end
      chk_int("ffff_half_period", n, 65536);
      chk_int("ffff_cnt_after", int'(dut.u_cnt.cnt_q), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_div_frec
